jtag_seq: RTL
=============

# jtag_seq

Command sequencer sitting directly upstream of the `jtag` shifter. It accepts one host command at a time over a valid/ready handshake, pushes the instruction word into the instruction FIFO when needed, and drives `work`/`op`/`len` into `jtag`. It then tracks `jtag`'s `busy` through the transaction and reports completion, or a protocol or timeout error, back to the host.

## Interface
- `DATA_INSTRACTION`, 10, instruction word width; must match `jtag`.
- `WAIT_BUSY_MAX`, 8, cycles allowed from `work` pulse to `busy` rising.
- `TIMEOUT`, 65535, maximum cycles `busy` may stay high (16-bit).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  1  1 = data (TDO) transaction, 0 = instruction transaction.
- `cmd_len`  in  16  transaction length in bits.
- `cmd_word`  in  DATA_INSTRACTION  instruction payload; used only when `cmd_op`=0.
- `done`  out  1  one-cycle pulse: transaction completed.
- `error`  out  1  one-cycle pulse: command rejected or transaction failed.
- `err_code`  out  2  cause, valid with `error`: 1 bad length, 2 no busy, 3 timeout.
- `txn_count`  out  16  number of completed transactions; wraps.
- `op`  out  1  to `jtag`.
- `len`  out  16  to `jtag`.
- `work`  out  1  to `jtag`; one-cycle start pulse.
- `busy`  in  1  from `jtag`.
- `wdata_instraction`  out  DATA_INSTRACTION  instruction FIFO write data.
- `wr_instraction`  out  1  instruction FIFO write strobe.
- `full_instraction`  in  1  instruction FIFO full.

## Operation
- All outputs are registered. Reset values are 0: `cmd_ready`, `done`, `error`, `err_code`, `txn_count`, `op`, `len`, `work`, `wdata_instraction`, `wr_instraction`. The state is IDLE.
- A command is accepted on a cycle where `cmd_valid` && `cmd_ready`. `cmd_ready` is 1 only in IDLE and drops on the cycle after acceptance.
- On accept, `cmd_op`, `cmd_len` and `cmd_word` are latched into `op`, `len` and `wdata_instraction`. `op` and `len` are held stable until the command leaves DONE or ERR, because `jtag` reads `len` throughout the transaction.
- Length check at accept:
  - `cmd_len`=0 is rejected with code 1.
  - `cmd_op`=0 with `cmd_len` > DATA_INSTRACTION is rejected with code 1.
  - A rejected command goes to ERR. No FIFO write and no `work` pulse occur.

States:
- IDLE -> LOAD when the command is valid and `op`=0.
- IDLE -> ISSUE when the command is valid and `op`=1.
- IDLE -> ERR when the command is invalid.
- LOAD:
  - While `full_instraction`=1, stay in LOAD with `wr_instraction`=0. There is no timeout in LOAD.
  - Otherwise pulse `wr_instraction` for one cycle, then go to ISSUE.
- ISSUE: pulse `work` for one cycle, clear the cycle counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - `busy`=1 -> RUN, with the counter cleared.
  - Counter reaches WAIT_BUSY_MAX -> ERR with code 2.
- RUN:
  - `busy`=0 -> DONE.
  - Counter reaches TIMEOUT -> ERR with code 3.
- DONE: pulse `done`, increment `txn_count` (modulo 2^16), go to IDLE.
- ERR: pulse `error` with `err_code`, go to IDLE.
- `busy` observed high while in IDLE, LOAD or ISSUE is ignored and does not block acceptance. The host is responsible for not issuing a command while `jtag` is stuck.
- The counter is 16 bits and saturates; it never wraps inside a state.

## Timing
- Instruction command accepted at cycle T:
  - T+1 LOAD, `wr_instraction`=1 if FIFO not full.
  - T+2 ISSUE.
  - T+3 `work`=1.
  - `jtag` raises `busy` at about T+4, so WAIT_BUSY sees it at T+4 or T+5.
- Data command accepted at T: `work`=1 at T+2.
- `done` asserts 2 cycles after the first cycle with `busy`=0 in RUN.
- `cmd_ready` returns to 1 on the cycle after `done` or `error`.
- Back-to-back commands: minimum gap is 1 idle cycle with `cmd_ready`=1.
- `rst_n` low mid-transaction:
  - All outputs are cleared asynchronously and the state returns to IDLE. A write already performed is not retracted.
  - After release, `cmd_ready`=1 at the first clock edge.

## Test plan
- Instruction, len=10, `cmd_word`=10'h2A5, FIFO not full, `busy` modelled high for 40 cycles -> exactly one write of 10'h2A5, one `work` pulse with `op`=0 and `len`=10, `done` once, `txn_count`=1.
- Data, len=8, `busy` high for 30 cycles -> no FIFO write, `work` pulse with `op`=1, `done` once, `len` stable the entire time.
- `full_instraction` held high for 20 cycles -> sequencer stays in LOAD with no write. The write occurs on the first cycle after `full_instraction` drops, and the transaction then completes normally.
- `cmd_len`=0, and separately `op`=0 with `cmd_len`=11 -> `error` pulse with `err_code`=1, no `work`, no write, `cmd_ready` back high.
- `busy` never rises -> `error` with `err_code`=2 WAIT_BUSY_MAX+1 cycles after `work`. With `TIMEOUT`=100 and `busy` stuck high -> `error` with `err_code`=3.
- `rst_n` pulled low in RUN -> all outputs 0 immediately. A new command after release completes with `txn_count` counting from 0.

Source files
------------

// File: rtl/jtag_seq.sv
// Command sequencer in front of the jtag shifter: accepts one host command, loads the
// instruction FIFO if needed, starts jtag, then follows busy to completion or error.
module jtag_seq #(
  parameter int DATA_INSTRACTION = 10,
  parameter int WAIT_BUSY_MAX    = 8,
  parameter int TIMEOUT          = 65535
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_op,
  input  logic [15:0]                 cmd_len,
  input  logic [DATA_INSTRACTION-1:0] cmd_word,
  output logic                        done,
  output logic                        error,
  output logic [1:0]                  err_code,
  output logic [15:0]                 txn_count,
  output logic                        op,
  output logic [15:0]                 len,
  output logic                        work,
  input  logic                        busy,
  output logic [DATA_INSTRACTION-1:0] wdata_instraction,
  output logic                        wr_instraction,
  input  logic                        full_instraction
);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_BUSY, RUN, DONE, ERR} state_t;

  state_t                        state, state_nx;
  logic [15:0]                   cnt, cnt_nx, cnt_inc;
  logic [1:0]                    cause, cause_nx;
  logic                          accept, cmd_bad;
  logic                          cmd_ready_nx, done_nx, error_nx, work_nx, wr_nx, op_nx;
  logic [1:0]                    err_code_nx;
  logic [15:0]                   len_nx, txn_nx;
  logic [DATA_INSTRACTION-1:0]   wdata_nx;

  assign accept  = cmd_valid && cmd_ready;
  assign cmd_bad = (cmd_len == 16'd0) ||
                   (!cmd_op && (32'(cmd_len) > DATA_INSTRACTION));
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= 16'd0;
      cause             <= 2'd0;
      cmd_ready         <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      err_code          <= 2'd0;
      txn_count         <= 16'd0;
      op                <= 1'b0;
      len               <= 16'd0;
      work              <= 1'b0;
      wdata_instraction <= '0;
      wr_instraction    <= 1'b0;
    end else begin
      state             <= state_nx;
      cnt               <= cnt_nx;
      cause             <= cause_nx;
      cmd_ready         <= cmd_ready_nx;
      done              <= done_nx;
      error             <= error_nx;
      err_code          <= err_code_nx;
      txn_count         <= txn_nx;
      op                <= op_nx;
      len               <= len_nx;
      work              <= work_nx;
      wdata_instraction <= wdata_nx;
      wr_instraction    <= wr_nx;
    end
  end

  // The cycle counter is shared by WAIT_BUSY and RUN; ISSUE and every other state clear it.
  always_comb begin
    state_nx = state;
    cnt_nx   = 16'd0;
    cause_nx = cause;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_bad) begin
            state_nx = ERR;
            cause_nx = 2'd1;
          end else begin
            state_nx = cmd_op ? ISSUE : LOAD;
          end
        end
      end
      LOAD: begin
        if (wr_instraction) state_nx = ISSUE;
      end
      ISSUE: state_nx = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy) begin
          state_nx = RUN;
        end else if (cnt == 16'(WAIT_BUSY_MAX - 1)) begin
          state_nx = ERR;
          cause_nx = 2'd2;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      RUN: begin
        if (!busy) begin
          state_nx = DONE;
        end else if (cnt == 16'(TIMEOUT - 1)) begin
          state_nx = ERR;
          cause_nx = 2'd3;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The FIFO write is decided from full one cycle ahead; LOAD leaves once the write is visible.
  always_comb begin
    cmd_ready_nx = (state_nx == IDLE) && (state != DONE) && (state != ERR);
    work_nx      = (state == ISSUE);
    done_nx      = (state == DONE);
    error_nx     = (state == ERR);
    err_code_nx  = (state == ERR) ? cause : 2'd0;
    txn_nx       = txn_count + {15'd0, (state == DONE)};
    wr_nx        = 1'b0;
    op_nx        = op;
    len_nx       = len;
    wdata_nx     = wdata_instraction;
    if (state == IDLE && accept) begin
      op_nx    = cmd_op;
      len_nx   = cmd_len;
      wdata_nx = cmd_word;
      wr_nx    = !cmd_bad && !cmd_op && !full_instraction;
    end else if (state == LOAD) begin
      wr_nx    = !wr_instraction && !full_instraction;
    end
  end

endmodule
